// File: rtl/urna_controle.sv
// Voting-machine session controller: collects two-digit codes, owns the vote
// counters and cycles the results pages on a fixed dwell timer.
module urna_controle #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned MAX_VOTOS   = 255,
    parameter int unsigned COD_C1      = 13,
    parameter int unsigned COD_C2      = 22
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       finish,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       confirma,
    input  logic       corrige,
    output logic [7:0] c1,
    output logic [7:0] c2,
    output logic [7:0] nulo,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic       vote_ack,
    output logic [1:0] sel,
    output logic       avanca,
    output logic [2:0] estado
);

    localparam int unsigned CW    = 8;
    localparam int unsigned DIGW  = 4;
    localparam int unsigned CODEW = 7;
    localparam int unsigned DW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DIGW-1:0] BLANK = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DIG1   = 3'd1,
        S_DIG2   = 3'd2,
        S_CONF   = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   c1_q, c1_d, c2_q, c2_d, nulo_q, nulo_d;
    logic [DIGW-1:0] d1_q, d1_d, d2_q, d2_d;
    logic            vote_ack_q, vote_ack_d;
    logic [1:0]      sel_q, sel_d;
    logic            avanca_q, avanca_d;
    logic [DW-1:0]   dwell_q, dwell_d;

    logic             digit_ok_c;
    logic [CODEW-1:0] code_c;

    assign digit_ok_c = digit_valid && (digit <= 4'd9);
    assign code_c     = CODEW'(d1_q) * CODEW'(10) + CODEW'(d2_q);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CW'(MAX_VOTOS)) ? v : v + CW'(1);
    endfunction

    // State register and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            c1_q       <= '0;
            c2_q       <= '0;
            nulo_q     <= '0;
            d1_q       <= BLANK;
            d2_q       <= BLANK;
            vote_ack_q <= 1'b0;
            sel_q      <= 2'd0;
            avanca_q   <= 1'b0;
            dwell_q    <= '0;
        end else begin
            state_q    <= state_d;
            c1_q       <= c1_d;
            c2_q       <= c2_d;
            nulo_q     <= nulo_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            vote_ack_q <= vote_ack_d;
            sel_q      <= sel_d;
            avanca_q   <= avanca_d;
            dwell_q    <= dwell_d;
        end
    end

    // Next-state logic; start outranks everything, finish is only honoured in DIG1
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_DIG1;
        end else begin
            unique case (state_q)
                S_DIG1: begin
                    if (finish)          state_d = S_RESULT;
                    else if (corrige)    state_d = S_DIG1;
                    else if (digit_ok_c) state_d = S_DIG2;
                end
                S_DIG2: begin
                    if (corrige)         state_d = S_DIG1;
                    else if (digit_ok_c) state_d = S_CONF;
                end
                S_CONF: begin
                    if (corrige || confirma) state_d = S_DIG1;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        c1_d       = c1_q;
        c2_d       = c2_q;
        nulo_d     = nulo_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        vote_ack_d = 1'b0;
        sel_d      = sel_q;
        avanca_d   = 1'b0;
        dwell_d    = dwell_q;
        if (start) begin
            c1_d    = '0;
            c2_d    = '0;
            nulo_d  = '0;
            d1_d    = BLANK;
            d2_d    = BLANK;
            sel_d   = 2'd0;
            dwell_d = '0;
        end else begin
            unique case (state_q)
                S_DIG1: begin
                    if (finish) begin
                        sel_d    = 2'd0;
                        dwell_d  = '0;
                        avanca_d = 1'b1;
                    end else if (corrige) begin
                        d1_d = BLANK;
                        d2_d = BLANK;
                    end else if (digit_ok_c) begin
                        d1_d = digit;
                    end
                end
                S_DIG2: begin
                    if (corrige) begin
                        d1_d = BLANK;
                        d2_d = BLANK;
                    end else if (digit_ok_c) begin
                        d2_d = digit;
                    end
                end
                S_CONF: begin
                    if (corrige) begin
                        d1_d = BLANK;
                        d2_d = BLANK;
                    end else if (confirma) begin
                        if (code_c == CODEW'(COD_C1))      c1_d   = sat_inc(c1_q);
                        else if (code_c == CODEW'(COD_C2)) c2_d   = sat_inc(c2_q);
                        else                               nulo_d = sat_inc(nulo_q);
                        d1_d       = BLANK;
                        d2_d       = BLANK;
                        vote_ack_d = 1'b1;
                    end
                end
                S_RESULT: begin
                    if (finish) begin
                        sel_d    = 2'd0;
                        dwell_d  = '0;
                        avanca_d = 1'b1;
                    end else if (dwell_q == DW'(HOLD_CYCLES - 1)) begin
                        dwell_d  = '0;
                        sel_d    = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                        avanca_d = 1'b1;
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign c1       = c1_q;
    assign c2       = c2_q;
    assign nulo     = nulo_q;
    assign d1       = d1_q;
    assign d2       = d2_q;
    assign vote_ack = vote_ack_q;
    assign sel      = sel_q;
    assign avanca   = avanca_q;
    assign estado   = state_q;

endmodule

// File: tb/tb_urna_controle.sv
// Directed bench for urna_controle, small build (HOLD_CYCLES = 4, MAX_VOTOS = 3).
module tb_urna_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, finish, digit_valid, confirma, corrige;
    logic [3:0] digit;
    logic [7:0] c1, c2, nulo;
    logic [3:0] d1, d2;
    logic       vote_ack, avanca;
    logic [1:0] sel;
    logic [2:0] estado;

    int n_vec = 0;
    int n_err = 0;

    urna_controle #(
        .HOLD_CYCLES(4),
        .MAX_VOTOS  (3),
        .COD_C1     (13),
        .COD_C2     (22)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .finish     (finish),
        .digit_valid(digit_valid),
        .digit      (digit),
        .confirma   (confirma),
        .corrige    (corrige),
        .c1         (c1),
        .c2         (c2),
        .nulo       (nulo),
        .d1         (d1),
        .d2         (d2),
        .vote_ack   (vote_ack),
        .sel        (sel),
        .avanca     (avanca),
        .estado     (estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Hold one input combination for a single clock, then release; returns on the following falling edge
    task automatic apply(input logic st, input logic fi, input logic dv,
                         input logic [3:0] dg, input logic cf, input logic co);
        @(negedge clock);
        start = st; finish = fi; digit_valid = dv; digit = dg; confirma = cf; corrige = co;
        @(negedge clock);
        start = 1'b0; finish = 1'b0; digit_valid = 1'b0; digit = 4'd0; confirma = 1'b0; corrige = 1'b0;
    endtask

    task automatic key(input logic [3:0] dg);
        apply(1'b0, 1'b0, 1'b1, dg, 1'b0, 1'b0);
    endtask

    task automatic vote(input logic [3:0] a, input logic [3:0] b);
        key(a);
        key(b);
        apply(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; finish = 1'b0; digit_valid = 1'b0; digit = 4'd0;
        confirma = 1'b0; corrige = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_estado", int'(estado), 0);
        check("rst_c1", int'(c1), 0);
        check("rst_nulo", int'(nulo), 0);
        check("rst_d1", int'(d1), 15);
        check("rst_d2", int'(d2), 15);
        check("rst_sel", int'(sel), 0);
        check("rst_ack", int'(vote_ack), 0);
        reset = 1'b0;

        // IDLE ignores keypad
        key(4'd5);
        check("idle_estado", int'(estado), 0);
        check("idle_d1", int'(d1), 15);

        apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("start_estado", int'(estado), 1);
        key(4'd1);
        check("dig1_estado", int'(estado), 2);
        check("dig1_d1", int'(d1), 1);
        key(4'd3);
        check("dig2_estado", int'(estado), 3);
        check("dig2_d2", int'(d2), 3);
        apply(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("v13_ack", int'(vote_ack), 1);
        check("v13_c1", int'(c1), 1);
        check("v13_c2", int'(c2), 0);
        check("v13_nulo", int'(nulo), 0);
        check("v13_estado", int'(estado), 1);
        check("v13_d1", int'(d1), 15);
        check("v13_d2", int'(d2), 15);
        @(negedge clock);
        check("v13_ack_drop", int'(vote_ack), 0);

        vote(4'd2, 4'd2);
        vote(4'd4, 4'd5);
        key(4'd9);
        apply(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check("corr_estado", int'(estado), 1);
        check("corr_d1", int'(d1), 15);
        vote(4'd2, 4'd2);
        check("mix_c1", int'(c1), 1);
        check("mix_c2", int'(c2), 2);
        check("mix_nulo", int'(nulo), 1);

        // corrige outranks confirma in CONF
        key(4'd1);
        key(4'd3);
        apply(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("both_estado", int'(estado), 1);
        check("both_c1", int'(c1), 1);
        check("both_ack", int'(vote_ack), 0);
        key(4'd12);
        check("d12_estado", int'(estado), 1);
        check("d12_d1", int'(d1), 15);

        // saturation at MAX_VOTOS = 3
        apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("clr_c2", int'(c2), 0);
        for (int i = 0; i < 4; i++) begin
            vote(4'd1, 4'd3);
            check("sat_ack", int'(vote_ack), 1);
        end
        check("sat_c1", int'(c1), 3);
        check("sat_nulo", int'(nulo), 0);

        // finish ignored in DIG2, honoured in DIG1
        key(4'd1);
        apply(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        check("fin_dig2_estado", int'(estado), 2);
        apply(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        check("res_estado", int'(estado), 4);
        check("res_sel0", int'(sel), 0);
        check("res_av0", int'(avanca), 1);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            check("res_sel", int'(sel), (i / 4) % 3);
            check("res_avanca", int'(avanca), (i % 4 == 0) ? 1 : 0);
        end
        repeat (4) @(negedge clock);
        check("res_sel1", int'(sel), 1);
        apply(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        check("refin_sel", int'(sel), 0);
        check("refin_av", int'(avanca), 1);
        key(4'd5);
        check("res_key_estado", int'(estado), 4);
        check("res_key_d1", int'(d1), 15);
        apply(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("res_frozen_c1", int'(c1), 3);

        // asynchronous reset in CONF drops partial vote and counters
        apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        vote(4'd1, 4'd3);
        check("pre_c1", int'(c1), 1);
        key(4'd1);
        key(4'd3);
        check("pre_conf", int'(estado), 3);
        @(negedge clock);
        confirma = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("arst_estado", int'(estado), 0);
        check("arst_c1", int'(c1), 0);
        check("arst_d1", int'(d1), 15);
        @(posedge clock);
        #1;
        check("arst_ack", int'(vote_ack), 0);
        @(negedge clock);
        confirma = 1'b0;
        reset = 1'b0;

        // start from RESULT
        apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        vote(4'd2, 4'd2);
        check("pre_c2", int'(c2), 1);
        apply(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        check("pre_res", int'(estado), 4);
        repeat (5) @(negedge clock);
        apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("rs_estado", int'(estado), 1);
        check("rs_c2", int'(c2), 0);
        check("rs_sel", int'(sel), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
